// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - memory-stage stall controller for a multi-cycle data memory
// Optional timeout abort: define MEM_TIMEOUT_EN.
module mem_stall_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        XM_memRead,
    input  logic        XM_memWrite,
    input  logic [15:0] XM_aluOut,
    input  logic [15:0] XM_writeData,
    input  logic        XM_flush,
    input  logic        XM_halt,
    output logic        stall,
    output logic [15:0] readData,
    output logic        err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid
);

    if (TIMEOUT < 2 || TIMEOUT > 31 || (32'd1 << CNT_W) <= 32'(TIMEOUT)) begin : g_bad_cfg
        $error("mem_stall_ctrl: TIMEOUT must be 2..31 and fit in CNT_W bits");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t      r_state;
    logic        r_wr;
    logic [15:0] r_read_data;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic        w_req;
    logic        w_issue;
    logic        w_in_wait;

    assign w_req     = (XM_memRead | XM_memWrite) & ~XM_flush & ~XM_halt;
    assign w_issue   = (r_state == ST_IDLE) & w_req;
    assign w_in_wait = (r_state == ST_WAIT);

    // The issue cycle stalls combinationally so XM holds until the response.
    assign stall     = w_issue | w_in_wait;
    assign mem_req   = w_issue;
    assign mem_wr    = w_issue & XM_memWrite;
    assign readData  = r_read_data;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_timeout;

    assign w_timeout = w_in_wait & ~mem_valid & (r_cnt == CNT_W'(TIMEOUT - 1));
    assign err       = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr        <= 1'b0;
            r_read_data <= 16'h0000;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state <= ST_WAIT;
                        r_wr    <= XM_memWrite;
                        r_addr  <= XM_aluOut;
                        r_wdata <= XM_writeData;
`ifdef MEM_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (mem_valid) begin
                        if (!r_wr) begin
                            r_read_data <= mem_rdata;
                        end
                        r_state <= ST_DONE;
`ifdef MEM_TIMEOUT_EN
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (!r_wr) begin
                            r_read_data <= 16'hFFFF;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                // The XM request is still visible here; it is consumed, not reissued.
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb/tb_mem_stall_ctrl.sv - self-checking bench for mem_stall_ctrl
module tb_mem_stall_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        XM_memRead, XM_memWrite, XM_flush, XM_halt, mem_valid;
    logic [15:0] XM_aluOut, XM_writeData, mem_rdata;
    logic        stall, err, mem_req, mem_wr;
    logic [15:0] readData, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .XM_memRead(XM_memRead), .XM_memWrite(XM_memWrite),
        .XM_aluOut(XM_aluOut), .XM_writeData(XM_writeData),
        .XM_flush(XM_flush), .XM_halt(XM_halt),
        .stall(stall), .readData(readData), .err(err),
        .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Transaction-level model: an access is either outstanding, just released, or absent.
    bit          m_busy = 0, m_rel = 0, m_write = 0, m_err = 0;
    int          m_waited = 0;
    logic [15:0] m_rd = 16'h0, m_addr = 16'h0, m_wdata = 16'h0;

    logic        s_stall, s_req, s_wr, s_err;
    logic [15:0] s_rd, s_addr, s_wdata;
    int          s_req_cyc;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    endtask

    task automatic tick();
        bit e_issue;
        @(negedge clk);
        s_stall = stall; s_req = mem_req; s_wr = mem_wr; s_err = err;
        s_rd = readData; s_addr = mem_addr; s_wdata = mem_wdata;
        if (mem_req === 1'b1) s_req_cyc = cyc;
        e_issue = !m_busy && !m_rel && (XM_memRead || XM_memWrite) && !XM_flush && !XM_halt;
        chk("stall",     {15'h0, stall},   {15'h0, e_issue || m_busy});
        chk("mem_req",   {15'h0, mem_req}, {15'h0, e_issue});
        chk("mem_wr",    {15'h0, mem_wr},  {15'h0, e_issue && XM_memWrite});
        chk("err",       {15'h0, err},     {15'h0, m_err});
        chk("readData",  readData,  m_rd);
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        if (rst) begin
            m_busy = 0; m_rel = 0; m_err = 0; m_waited = 0;
            m_rd = 16'h0; m_addr = 16'h0; m_wdata = 16'h0;
        end else begin
            m_err = 0;
            if (m_rel) begin
                m_rel = 0;
            end else if (m_busy) begin
                if (mem_valid) begin
                    if (!m_write) m_rd = mem_rdata;
                    m_busy = 0; m_rel = 1;
                end else begin
                    m_waited++;
`ifdef MEM_TIMEOUT_EN
                    if (m_waited == TIMEOUT) begin
                        m_err = 1;
                        if (!m_write) m_rd = 16'hFFFF;
                        m_busy = 0; m_rel = 1;
                    end
`endif
                end
            end else if (e_issue) begin
                m_busy = 1; m_write = XM_memWrite; m_waited = 0;
                m_addr = XM_aluOut; m_wdata = XM_writeData;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Holds the XM request for the whole access; memory answers lat cycles after issue.
    task automatic run_access(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                              input int lat, input logic [15:0] rdata,
                              output int n_stall, output int n_req, output int n_wr);
        XM_memRead = !wr; XM_memWrite = wr; XM_aluOut = addr; XM_writeData = wdata;
        n_stall = 0; n_req = 0; n_wr = 0;
        for (int c = 0; c <= lat + 1; c++) begin
            mem_valid = (c == lat);
            mem_rdata = (c == lat) ? rdata : 16'($urandom);
            tick();
            n_stall += int'(s_stall); n_req += int'(s_req); n_wr += int'(s_wr);
        end
        XM_memRead = 0; XM_memWrite = 0; mem_valid = 0;
    endtask

    initial begin
        int ns, nr, nw, first_req;
        rst = 1; XM_memRead = 0; XM_memWrite = 0; XM_flush = 0; XM_halt = 0;
        XM_aluOut = 0; XM_writeData = 0; mem_valid = 0; mem_rdata = 0;
        tick(); tick();
        chk("reset stall", {15'h0, s_stall}, 16'h0);
        chk("reset readData", s_rd, 16'h0000);
        chk("reset mem_req", {15'h0, s_req}, 16'h0);
        rst = 0;
        tick();

        run_access(1'b0, 16'h0040, 16'h0, 1, 16'hBEEF, ns, nr, nw);
        chk("load1 stall cycles", 16'(ns), 16'd2);
        chk("load1 req count", 16'(nr), 16'd1);
        chk("load1 wr count", 16'(nw), 16'd0);
        chk("load1 readData", s_rd, 16'hBEEF);
        chk("load1 done stall", {15'h0, s_stall}, 16'h0);

        run_access(1'b1, 16'h0010, 16'h1234, 3, 16'h5555, ns, nr, nw);
        chk("store stall cycles", 16'(ns), 16'd4);
        chk("store wr count", 16'(nw), 16'd1);
        chk("store wdata held", s_wdata, 16'h1234);
        chk("store addr held", s_addr, 16'h0010);
        chk("store readData kept", s_rd, 16'hBEEF);

        XM_memRead = 1; XM_flush = 1; ns = 0; nr = 0;
        for (int i = 0; i < 3; i++) begin tick(); ns += int'(s_stall); nr += int'(s_req); end
        XM_flush = 0; XM_halt = 1;
        for (int i = 0; i < 3; i++) begin tick(); ns += int'(s_stall); nr += int'(s_req); end
        XM_halt = 0; XM_memRead = 0;
        chk("flush/halt req", 16'(nr), 16'd0);
        chk("flush/halt stall", 16'(ns), 16'd0);

        XM_memRead = 1; XM_aluOut = 16'h0080; mem_valid = 0;
        tick(); tick();
        rst = 1;
        tick();
        chk("rst-in-wait stall", {15'h0, s_stall}, 16'h1);
        rst = 0; XM_memRead = 0;
        tick();
        chk("after rst stall", {15'h0, s_stall}, 16'h0);
        chk("after rst readData", s_rd, 16'h0000);
        mem_valid = 1; mem_rdata = 16'hDEAD;
        tick();
        mem_valid = 0;
        tick();
        chk("late valid ignored", s_rd, 16'h0000);
        chk("late valid stall", {15'h0, s_stall}, 16'h0);

        run_access(1'b0, 16'h0100, 16'h0, 2, 16'h0001, ns, nr, nw);
        first_req = s_req_cyc;
        chk("b2b load1 readData", s_rd, 16'h0001);
        run_access(1'b0, 16'h0102, 16'h0, 2, 16'h0002, ns, nr, nw);
        chk("b2b load2 readData", s_rd, 16'h0002);
        chk("b2b req spacing", 16'(s_req_cyc - first_req), 16'd4);
        tick();

`ifdef MEM_TIMEOUT_EN
        begin
            int n_err = 0;
            int n_st  = 0;
            int guard = 0;
            XM_memRead = 1; XM_aluOut = 16'h0200; mem_valid = 0;
            tick();
            while (s_stall && guard < 40) begin
                n_st++; guard++;
                tick();
                n_err += int'(s_err);
            end
            XM_memRead = 0;
            chk("timeout bounded", {15'h0, guard < 40}, 16'h1);
            chk("timeout stall cycles", 16'(n_st), 16'(TIMEOUT + 1));
            chk("timeout err pulses", 16'(n_err), 16'd1);
            chk("timeout readData", s_rd, 16'hFFFF);
            tick();
        end
`endif

        for (int blk = 0; blk < 6; blk++) begin
            int p_valid = (blk % 2 == 0) ? 30 : 4;
            for (int i = 0; i < 500; i++) begin
                rst          = ($urandom_range(0, 199) == 0);
                XM_memRead   = ($urandom_range(0, 2) == 0);
                XM_memWrite  = ($urandom_range(0, 3) == 0);
                XM_flush     = ($urandom_range(0, 7) == 0);
                XM_halt      = ($urandom_range(0, 7) == 0);
                XM_aluOut    = 16'($urandom);
                XM_writeData = 16'($urandom);
                mem_valid    = ($urandom_range(0, 99) < p_valid);
                mem_rdata    = 16'($urandom);
                if (rst) begin XM_memRead = 0; XM_memWrite = 0; end
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
